// File: rtl/enc8_pkg.sv
// Shared widths and types for the 8-to-3 sequential event encoder.
package enc8_pkg;
  localparam int unsigned N  = 8;
  localparam int unsigned CW = 3;

  typedef logic [CW-1:0] code_t;
  typedef logic [N-1:0]  req_t;
endpackage

// File: rtl/enc8_pick.sv
// Combinational arbiter: round-robin from ptr upward, or fixed priority with the highest index winning.
module enc8_pick
  import enc8_pkg::*;
(
  input  req_t  req,
  input  code_t ptr,
  input  logic  rr,
  output code_t idx,
  output logic  any
);

  code_t cand;
  logic  found;

  always_comb begin
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    if (rr) begin
      // Walk upward from ptr with 3-bit wrap; the first hit wins.
      for (int unsigned k = 0; k < N; k++) begin
        cand = CW'(ptr + CW'(k));
        if (!found && req[cand]) begin
          idx   = cand;
          found = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        if (req[k]) idx = CW'(k);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/encoder8to3_seq.sv
// Captures events on eight request lines, holds them pending and emits their
// 3-bit indices one at a time over a valid/ready handshake.
module encoder8to3_seq
  import enc8_pkg::*;
#(
  parameter bit EDGE = 1'b1,
  parameter bit RR   = 1'b1
) (
  input  logic  CELCLK,
  input  logic  CELRST,
  input  logic  CELV,
  input  logic  CELG,
  input  logic  SUB,
  input  req_t  i,
  input  logic  clr,
  output code_t o,
  output logic  ov,
  input  logic  ordy,
  output req_t  pend,
  output logic  ovf
);

  req_t  ip_q, ip_d;
  req_t  pend_q, pend_d;
  code_t ptr_q, ptr_d;
  code_t o_q, o_d;
  logic  ov_q, ov_d;
  logic  ovf_q, ovf_d;

  req_t  evt_c;
  req_t  moved_c;
  logic  load_c;
  logic  drop_c;
  code_t pick_idx;
  logic  pick_any;

  // Power and substrate pins carry no logic function.
  logic  unused_pins;
  assign unused_pins = ^{CELV, CELG, SUB};

  enc8_pick u_pick (
    .req (pend_q),
    .ptr (ptr_q),
    .rr  (RR),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Next-state: event detect, output load, pending update and overflow.
  always_comb begin
    evt_c   = EDGE ? (i & ~ip_q) : i;
    ip_d    = EDGE ? i : '0;
    load_c  = !ov_q || ordy;
    moved_c = '0;
    o_d     = o_q;
    ov_d    = ov_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;

    if (load_c) begin
      if (pick_any) begin
        o_d     = pick_idx;
        ov_d    = 1'b1;
        ptr_d   = CW'(pick_idx + CW'(1));
        moved_c = N'(1) << pick_idx;
      end else begin
        ov_d = 1'b0;
      end
    end

    // A new event on a bit being moved out the same cycle is kept, not dropped.
    pend_d = (pend_q & ~moved_c) | evt_c;
    drop_c = EDGE && (|(evt_c & pend_q & ~moved_c));

    if (clr)    ovf_d = 1'b0;
    if (drop_c) ovf_d = 1'b1;
  end

  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      ip_q   <= '0;
      pend_q <= '0;
      ptr_q  <= '0;
      o_q    <= '0;
      ov_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      ip_q   <= ip_d;
      pend_q <= pend_d;
      ptr_q  <= ptr_d;
      o_q    <= o_d;
      ov_q   <= ov_d;
      ovf_q  <= ovf_d;
    end
  end

  assign o    = o_q;
  assign ov   = ov_q;
  assign pend = pend_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_encoder8to3_seq.sv
// Scoreboard bench for encoder8to3_seq: round-robin, fixed-priority and level-mode instances.
module tb_encoder8to3_seq;

  logic       clk;
  logic       rst;
  logic [7:0] i_drv;
  logic [7:0] i_lv;
  logic       clr;
  logic       ordy;

  logic [2:0] o_rr, o_fp, o_lv;
  logic       ov_rr, ov_fp, ov_lv;
  logic [7:0] pend_rr, pend_fp, pend_lv;
  logic       ovf_rr, ovf_fp, ovf_lv;

  logic [2:0] q_rr[$];
  logic [2:0] q_fp[$];
  logic [2:0] q_lv[$];

  int n_cmp = 0;
  int n_err = 0;

  encoder8to3_seq #(.EDGE(1'b1), .RR(1'b1)) u_rr (
    .CELCLK(clk), .CELRST(rst), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
    .i(i_drv), .clr(clr), .o(o_rr), .ov(ov_rr), .ordy(ordy),
    .pend(pend_rr), .ovf(ovf_rr)
  );

  encoder8to3_seq #(.EDGE(1'b1), .RR(1'b0)) u_fp (
    .CELCLK(clk), .CELRST(rst), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
    .i(i_drv), .clr(clr), .o(o_fp), .ov(ov_fp), .ordy(ordy),
    .pend(pend_fp), .ovf(ovf_fp)
  );

  encoder8to3_seq #(.EDGE(1'b0), .RR(1'b1)) u_lv (
    .CELCLK(clk), .CELRST(rst), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
    .i(i_lv), .clr(clr), .o(o_lv), .ov(ov_lv), .ordy(ordy),
    .pend(pend_lv), .ovf(ovf_lv)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Each accepted code is compared against the head of its instance queue.
  always @(negedge clk) begin
    if (!rst && ov_rr && ordy) begin
      if (q_rr.size() == 0) chk("rr_extra_code", 32'(q_rr.size()), 1);
      else                  chk("rr_code", o_rr, q_rr.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && ov_fp && ordy) begin
      if (q_fp.size() == 0) chk("fp_extra_code", 32'(q_fp.size()), 1);
      else                  chk("fp_code", o_fp, q_fp.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && ov_lv && ordy) begin
      if (q_lv.size() == 0) chk("lv_extra_code", 32'(q_lv.size()), 1);
      else                  chk("lv_code", o_lv, q_lv.pop_front());
    end
  end

  initial begin
    rst   = 1'b1;
    i_drv = '0;
    i_lv  = '0;
    clr   = 1'b0;
    ordy  = 1'b0;
    tick(2);
    chk("rst_ov", ov_rr, 0);
    chk("rst_o", o_rr, 0);
    chk("rst_pend", pend_rr, 0);
    chk("rst_ovf", ovf_rr, 0);
    rst = 1'b0;
    tick(1);

    // Single event on bit 5, two edges to valid, one cycle wide.
    ordy = 1'b1;
    q_rr.push_back(3'd5);
    q_fp.push_back(3'd5);
    i_drv = 8'h20;
    tick(1);
    i_drv = '0;
    chk("single_pend", pend_rr, 8'h20);
    chk("single_ov_early", ov_rr, 0);
    tick(1);
    chk("single_ov", ov_rr, 1);
    chk("single_o", o_rr, 5);
    chk("single_pend_clr", pend_rr, 0);
    tick(1);
    chk("single_ov_drop", ov_rr, 0);

    // Ordering from ptr=6: RR gives 6,0,2; fixed priority gives 6,2,0.
    q_rr.push_back(3'd6); q_rr.push_back(3'd0); q_rr.push_back(3'd2);
    q_fp.push_back(3'd6); q_fp.push_back(3'd2); q_fp.push_back(3'd0);
    i_drv = 8'h45;
    tick(1);
    i_drv = '0;
    tick(4);
    chk("order_rr_idle", ov_rr, 0);
    chk("order_fp_idle", ov_fp, 0);

    // Backpressure after reset (ptr=0).
    ordy = 1'b0;
    rst  = 1'b1;
    tick(1);
    rst  = 1'b0;
    i_drv = 8'h81;
    tick(1);
    i_drv = '0;
    tick(1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_rr_ov", ov_rr, 1);
      chk("bp_rr_o", o_rr, 0);
      chk("bp_rr_pend", pend_rr, 8'h80);
      chk("bp_fp_o", o_fp, 7);
      chk("bp_fp_pend", pend_fp, 8'h01);
      tick(1);
    end
    q_rr.push_back(3'd0); q_rr.push_back(3'd7);
    q_fp.push_back(3'd7); q_fp.push_back(3'd0);
    ordy = 1'b1;
    tick(1);
    chk("bp_rr_next", o_rr, 7);
    tick(1);
    chk("bp_rr_empty", ov_rr, 0);

    // Drop and clear: output and pend[3] both full, then a third edge on i[3].
    ordy = 1'b0;
    i_drv = 8'h08; tick(1);
    i_drv = 8'h00; tick(1);
    i_drv = 8'h08; tick(1);
    i_drv = 8'h00; tick(1);
    chk("drop_ovf_pre", ovf_rr, 0);
    i_drv = 8'h08; tick(1);
    i_drv = 8'h00; tick(1);
    chk("drop_ovf_rr", ovf_rr, 1);
    chk("drop_ovf_fp", ovf_fp, 1);
    chk("drop_pend", pend_rr, 8'h08);
    chk("drop_o", o_rr, 3);
    clr = 1'b1; tick(1);
    clr = 1'b0;
    chk("clr_ovf", ovf_rr, 0);
    i_drv = 8'h08; clr = 1'b1; tick(1);
    i_drv = 8'h00; clr = 1'b0;
    chk("clr_vs_drop_ovf", ovf_rr, 1);
    q_rr.push_back(3'd3); q_rr.push_back(3'd3);
    q_fp.push_back(3'd3); q_fp.push_back(3'd3);
    ordy = 1'b1;
    tick(3);
    chk("drop_drain_ov", ov_rr, 0);
    chk("drop_drain_pend", pend_rr, 0);
    clr = 1'b1; tick(1);
    clr = 1'b0;
    chk("drop_final_clr", ovf_rr, 0);

    // Collision: pend[2] moved out on the same edge as a new rising edge on i[2].
    ordy = 1'b0;
    i_drv = 8'h01; tick(1);
    i_drv = 8'h00; tick(1);
    i_drv = 8'h04; tick(1);
    i_drv = 8'h00; tick(1);
    q_rr.push_back(3'd0); q_rr.push_back(3'd2); q_rr.push_back(3'd2);
    q_fp.push_back(3'd0); q_fp.push_back(3'd2); q_fp.push_back(3'd2);
    ordy = 1'b1;
    i_drv = 8'h04;
    tick(1);
    i_drv = 8'h00;
    chk("coll_pend", pend_rr, 8'h04);
    chk("coll_o", o_rr, 2);
    chk("coll_ovf", ovf_rr, 0);
    tick(2);
    chk("coll_idle", ov_rr, 0);

    // Reset while a code is held and F0 is pending.
    ordy = 1'b0;
    i_drv = 8'h01; tick(1);
    i_drv = 8'h00; tick(1);
    i_drv = 8'hF0; tick(1);
    i_drv = 8'h00;
    chk("mid_pend", pend_rr, 8'hF0);
    chk("mid_ov", ov_rr, 1);
    rst = 1'b1; tick(1);
    rst = 1'b0;
    chk("mid_rst_o", o_rr, 0);
    chk("mid_rst_ov", ov_rr, 0);
    chk("mid_rst_pend", pend_rr, 0);
    chk("mid_rst_fp_pend", pend_fp, 0);
    ordy = 1'b1;
    tick(4);
    chk("mid_rst_quiet", ov_rr, 0);
    q_rr.push_back(3'd0); q_rr.push_back(3'd7);
    q_fp.push_back(3'd7); q_fp.push_back(3'd0);
    i_drv = 8'h81; tick(1);
    i_drv = 8'h00; tick(4);
    chk("mid_after_idle", ov_rr, 0);

    // Level mode: a held line re-pends after each move and never flags a drop.
    q_lv.push_back(3'd3); q_lv.push_back(3'd3); q_lv.push_back(3'd3);
    i_lv = 8'h08;
    tick(1);
    chk("lv_pend0", pend_lv, 8'h08);
    tick(1);
    chk("lv_pend1", pend_lv, 8'h08);
    chk("lv_ovf1", ovf_lv, 0);
    tick(1);
    i_lv = 8'h00;
    tick(3);
    chk("lv_idle", ov_lv, 0);
    chk("lv_idle_pend", pend_lv, 0);
    ordy = 1'b0;
    i_lv = 8'h10;
    tick(3);
    chk("lv_hold_ovf", ovf_lv, 0);
    chk("lv_hold_pend", pend_lv, 8'h10);
    chk("lv_hold_o", o_lv, 4);
    i_lv = 8'h00;
    q_lv.push_back(3'd4); q_lv.push_back(3'd4);
    ordy = 1'b1;
    tick(3);
    chk("lv_hold_idle", ov_lv, 0);

    chk("rr_left", 32'(q_rr.size()), 0);
    chk("fp_left", 32'(q_fp.size()), 0);
    chk("lv_left", 32'(q_lv.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
